boot_sequencer: RTL

// - Upstream of the processor core: streams 9-bit machine code into instruction memory, holds the core
//   in reset while loading, releases it, then watches the core's Done and counts run cycles.
// - Gives the bench/host one start-to-finish handshake per program: load, run, finish or fault.

---
 rtl/boot_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer
//   Loads a program into instruction memory while holding the core in reset,
//   releases the core, then counts run cycles until core_done or a timeout.
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   start               begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_ready   program word handshake; in_data word, in_last final word
//   im_wr_en/im_addr/im_wdat  instruction memory write port
//   core_reset          active-high reset to the core
//   core_done           core finished indication
//   busy                high in LOAD, RST, RUN
//   finished/timed_out/overflow  sticky status flags
//   prog_len            words written by the last load
//   cycle_count         RUN cycles observed before core_done
module boot_sequencer #(
  parameter int IW         = 9,
  parameter int AW         = 8,
  parameter int CW         = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          im_wr_en,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdat,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic          overflow,
  output logic [AW:0]   prog_len,
  output logic [CW-1:0] cycle_count
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic          finished_q, finished_d;
  logic          timed_out_q, timed_out_d;
  logic          overflow_q, overflow_d;
  logic          in_ready_q, in_ready_d;
  logic          core_reset_q, core_reset_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prog_len_d  = prog_len_q;
    cycle_d     = cycle_q;
    rst_cnt_d   = rst_cnt_q;
    finished_d  = finished_q;
    timed_out_d = timed_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          prog_len_d  = '0;
          cycle_d     = '0;
          finished_d  = 1'b0;
          timed_out_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          prog_len_d = prog_len_q + 1'b1;
          // Address saturates at the top so word 0 can never be overwritten.
          if (addr_q != '1) addr_d = addr_q + 1'b1;
          if (in_last) begin
            state_d   = S_RST;
            rst_cnt_d = '0;
          end else if (addr_q == '1) begin
            state_d    = S_ERR;
            overflow_d = 1'b1;
          end
        end
      end
      S_RST: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = S_RUN;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_RUN: begin
        // core_done takes priority over an expiring timeout.
        if (core_done) begin
          state_d    = S_DONE;
          finished_d = 1'b1;
        end else if (cycle_q == CW'(TIMEOUT)) begin
          state_d     = S_ERR;
          timed_out_d = 1'b1;
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with state_q.
    in_ready_d   = (state_d == S_LOAD);
    core_reset_d = (state_d != S_RUN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RST) || (state_d == S_RUN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      prog_len_q   <= '0;
      cycle_q      <= '0;
      rst_cnt_q    <= '0;
      finished_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      prog_len_q   <= prog_len_d;
      cycle_q      <= cycle_d;
      rst_cnt_q    <= rst_cnt_d;
      finished_q   <= finished_d;
      timed_out_q  <= timed_out_d;
      overflow_q   <= overflow_d;
      in_ready_q   <= in_ready_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign im_wr_en    = (state_q == S_LOAD) && in_valid;
  assign im_addr     = addr_q;
  assign im_wdat     = in_data;
  assign in_ready    = in_ready_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign overflow    = overflow_q;
  assign prog_len    = prog_len_q;
  assign cycle_count = cycle_q;

endmodule
